// File: rtl/ecsu_pkg.sv
// Shared types and default thresholds for the Emergency Climate Sensor Unit.
package ecsu_pkg;

  typedef enum logic [1:0] {
    ALL_CLEAR  = 2'b00,
    CAUTION    = 2'b01,
    HIGH_ALERT = 2'b10,
    EMERGENCY  = 2'b11
  } ecsu_state_t;

  typedef enum logic [1:0] {
    VIS_CLEAR    = 2'b00,
    VIS_MODERATE = 2'b01,
    VIS_LOW      = 2'b10,
    VIS_POOR     = 2'b11
  } ecsu_vis_t;

  localparam int DEF_CAUTION_WIND = 10;
  localparam int DEF_HIGH_WIND    = 15;
  localparam int DEF_EMERG_WIND   = 20;
  localparam int DEF_HIGH_TEMP    = 35;
  localparam int DEF_EMERG_TEMP   = 40;

endpackage

// File: rtl/ecsu_cond_decode.sv
// Combinational decode of raw weather inputs into the transition conditions of the ECSU FSM.
module ecsu_cond_decode
  import ecsu_pkg::*;
#(
  parameter int CAUTION_WIND = DEF_CAUTION_WIND,
  parameter int HIGH_WIND    = DEF_HIGH_WIND,
  parameter int EMERG_WIND   = DEF_EMERG_WIND,
  parameter int HIGH_TEMP    = DEF_HIGH_TEMP,
  parameter int EMERG_TEMP   = DEF_EMERG_TEMP
) (
  input  logic       thunderstorm,
  input  logic [5:0] wind,
  input  logic [1:0] visibility,
  input  logic [7:0] temperature,
  output logic       caution_cond,
  output logic       clear_cond,
  output logic       high_cond,
  output logic       deescalate_cond,
  output logic       emerg_cond
);

  localparam logic [5:0]        L_CAUTION_WIND = 6'(CAUTION_WIND);
  localparam logic [5:0]        L_HIGH_WIND    = 6'(HIGH_WIND);
  localparam logic [5:0]        L_EMERG_WIND   = 6'(EMERG_WIND);
  localparam logic signed [7:0] L_HIGH_TEMP    = 8'(HIGH_TEMP);
  localparam logic signed [7:0] L_EMERG_TEMP   = 8'(EMERG_TEMP);

  logic signed [7:0] w_temp;
  logic              w_temp_high;
  logic              w_temp_emerg;

  assign w_temp = $signed(temperature);

  // Temperature limits are symmetric: magnitude above the threshold in either direction.
  assign w_temp_high  = (w_temp > L_HIGH_TEMP)  || (w_temp < -L_HIGH_TEMP);
  assign w_temp_emerg = (w_temp > L_EMERG_TEMP) || (w_temp < -L_EMERG_TEMP);

  assign caution_cond    = (wind > L_CAUTION_WIND) || (visibility == VIS_MODERATE);
  assign clear_cond      = (wind <= L_CAUTION_WIND) && (visibility == VIS_CLEAR);
  assign high_cond       = thunderstorm || (wind > L_HIGH_WIND) || w_temp_high ||
                           (visibility == VIS_POOR);
  assign deescalate_cond = !thunderstorm && (wind <= L_CAUTION_WIND) && !w_temp_high &&
                           (visibility == VIS_MODERATE);
  assign emerg_cond      = w_temp_emerg || (wind > L_EMERG_WIND);

endmodule

// File: rtl/ecsu.sv
// Emergency Climate Sensor Unit: Moore FSM stepping one alert level per clock with registered flags.
module ecsu
  import ecsu_pkg::*;
#(
  parameter int CAUTION_WIND = DEF_CAUTION_WIND,
  parameter int HIGH_WIND    = DEF_HIGH_WIND,
  parameter int EMERG_WIND   = DEF_EMERG_WIND,
  parameter int HIGH_TEMP    = DEF_HIGH_TEMP,
  parameter int EMERG_TEMP   = DEF_EMERG_TEMP
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       thunderstorm,
  input  logic [5:0] wind,
  input  logic [1:0] visibility,
  input  logic [7:0] temperature,
  output logic       severe_weather,
  output logic       emergency_landing_alert,
  output logic [1:0] ECSU_state
);

  ecsu_state_t r_state;
  ecsu_state_t w_next;
  logic        r_severe;
  logic        r_emerg;
  logic        w_caution, w_clear, w_high, w_deesc, w_emerg;

  ecsu_cond_decode #(
    .CAUTION_WIND (CAUTION_WIND),
    .HIGH_WIND    (HIGH_WIND),
    .EMERG_WIND   (EMERG_WIND),
    .HIGH_TEMP    (HIGH_TEMP),
    .EMERG_TEMP   (EMERG_TEMP)
  ) u_decode (
    .thunderstorm    (thunderstorm),
    .wind            (wind),
    .visibility      (visibility),
    .temperature     (temperature),
    .caution_cond    (w_caution),
    .clear_cond      (w_clear),
    .high_cond       (w_high),
    .deescalate_cond (w_deesc),
    .emerg_cond      (w_emerg)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ALL_CLEAR:  if (w_caution) w_next = CAUTION;
      CAUTION: begin
        if (w_high)       w_next = HIGH_ALERT;
        else if (w_clear) w_next = ALL_CLEAR;
      end
      HIGH_ALERT: begin
        if (w_emerg)      w_next = EMERGENCY;
        else if (w_deesc) w_next = CAUTION;
      end
      EMERGENCY:  w_next = EMERGENCY;
      default:    w_next = ALL_CLEAR;
    endcase
  end

  // Flags decode the next state so they update on the same edge as the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ALL_CLEAR;
      r_severe <= 1'b0;
      r_emerg  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_severe <= (w_next == HIGH_ALERT) || (w_next == EMERGENCY);
      r_emerg  <= (w_next == EMERGENCY);
    end
  end

  assign ECSU_state              = r_state;
  assign severe_weather          = r_severe;
  assign emergency_landing_alert = r_emerg;

endmodule

// File: tb/tb_ecsu.sv
// Directed self-checking bench for ecsu with an alert-level reference model checked every cycle.
module tb_ecsu;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       thunderstorm = 1'b0;
  logic [5:0] wind = '0;
  logic [1:0] visibility = '0;
  logic [7:0] temperature = '0;
  logic       severe_weather;
  logic       emergency_landing_alert;
  logic [1:0] ECSU_state;

  int errors = 0;
  int checks = 0;
  int mlvl   = 0;
  bit mvalid = 1'b0;

  ecsu dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .thunderstorm            (thunderstorm),
    .wind                    (wind),
    .visibility              (visibility),
    .temperature             (temperature),
    .severe_weather          (severe_weather),
    .emergency_landing_alert (emergency_landing_alert),
    .ECSU_state              (ECSU_state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Alert level 0..3; rules stated directly in integer arithmetic.
  function automatic int next_level(int lvl, bit th, int w, int v, int t);
    int a;
    bit thigh, temg;
    a     = (t < 0) ? -t : t;
    thigh = a > 35;
    temg  = a > 40;
    case (lvl)
      0: return (w > 10 || v == 1) ? 1 : 0;
      1: if (th || w > 15 || thigh || v == 3) return 2;
         else if (w <= 10 && v == 0) return 0;
         else return 1;
      2: if (temg || w > 20) return 3;
         else if (!th && w <= 10 && !thigh && v == 1) return 1;
         else return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      mlvl   = 0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      mlvl = next_level(mlvl, thunderstorm, int'(wind), int'(visibility),
                        int'($signed(temperature)));
    end
  end

  always @(negedge CLK) begin
    if (mvalid) begin
      chk("model_state", int'(ECSU_state), mlvl);
      chk("model_severe", int'(severe_weather), (mlvl >= 2) ? 1 : 0);
      chk("model_emerg", int'(emergency_landing_alert), (mlvl == 3) ? 1 : 0);
    end
  end

  task automatic expect_lvl(input string name, input int exp);
    chk({name, "_state"}, int'(ECSU_state), exp);
    chk({name, "_severe"}, int'(severe_weather), (exp >= 2) ? 1 : 0);
    chk({name, "_emerg"}, int'(emergency_landing_alert), (exp == 3) ? 1 : 0);
    chk({name, "_model"}, mlvl, exp);
  endtask

  task automatic step(input string name, input bit th, input int w, input int v,
                      input int t, input int exp);
    @(negedge CLK);
    RST          = 1'b0;
    thunderstorm = th;
    wind         = 6'(w);
    visibility   = 2'(v);
    temperature  = 8'(t);
    @(posedge CLK);
    #1;
    expect_lvl(name, exp);
  endtask

  task automatic do_reset(input string name);
    @(negedge CLK);
    RST          = 1'b1;
    thunderstorm = 1'b0;
    wind         = '0;
    visibility   = '0;
    temperature  = '0;
    @(posedge CLK);
    #1;
    expect_lvl(name, 0);
  endtask

  initial begin
    do_reset("reset");

    step("ac_wind12", 0, 12, 0, 0, 1);
    step("ca_clear", 0, 5, 0, 0, 0);
    step("ac_vis01", 0, 0, 1, 0, 1);

    step("ca_thunder", 1, 5, 1, 25, 2);
    step("ha_deesc", 0, 5, 1, 25, 1);
    step("ca_to_clear", 0, 3, 0, -5, 0);
    step("ac_vis11", 0, 3, 3, -5, 0);

    for (int i = 0; i < 5; i++)
      step("escalate", 0, 25, 2, 0, (i < 3) ? i + 1 : 3);
    step("emerg_hold", 0, 0, 0, 0, 3);
    do_reset("reset_emerg");

    step("ac_wind15", 0, 15, 1, 0, 1);
    step("ca_wind15", 0, 15, 1, 0, 1);
    step("ca_temp40", 0, 15, 1, 40, 2);
    step("ha_temp40", 0, 15, 1, 40, 2);
    step("ha_deesc2", 0, 5, 1, 25, 1);
    step("ca_wind25", 0, 25, 1, -40, 2);
    step("ha_wind25", 0, 25, 1, -40, 3);
    do_reset("reset2");

    step("ac_wind11", 0, 11, 0, 0, 1);
    step("ca_wind16", 0, 16, 0, 0, 2);
    step("ha_tm41", 0, 0, 0, -41, 3);
    do_reset("reset3");

    step("ac_wind11b", 0, 11, 0, 0, 1);
    step("ca_tm36", 0, 0, 2, -36, 2);
    step("ha_tm40", 0, 0, 1, -40, 2);
    step("ha_wind20", 0, 20, 0, 0, 2);
    step("ha_wind21", 0, 21, 0, 0, 3);
    do_reset("reset4");

    // Input pulse between edges must not be seen by the next edge.
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #2 wind = 6'd30;
    #2 wind = 6'd0;
    @(posedge CLK);
    #1;
    expect_lvl("glitch", 0);

    @(negedge CLK);
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecsu.md
Name: ecsu

Overview:
- Emergency Climate Sensor Unit: a single-clock Moore FSM that classifies current weather inputs into one of four alert levels.
- Drives a severe-weather flag and an emergency-landing alert for downstream airport/air-traffic control logic.
- Evaluates inputs once per rising clock edge and moves at most one alert level per cycle.

Parameters:
- CAUTION_WIND, 10, wind above this (strict) is a caution condition.
- HIGH_WIND, 15, wind above this (strict) is a high-alert condition.
- EMERG_WIND, 20, wind above this (strict) is an emergency condition.
- HIGH_TEMP, 35, |temperature| above this (strict) is a high-alert condition.
- EMERG_TEMP, 40, |temperature| above this (strict) is an emergency condition.

Ports:
- CLK  input  1  system clock; rising edge active.
- RST  input  1  synchronous, active-high reset.
- thunderstorm  input  1  thunderstorm present.
- wind  input  6  unsigned wind speed.
- visibility  input  2  00 clear, 01 moderate, 10 low, 11 very poor.
- temperature  input  8  signed two's-complement temperature.
- severe_weather  output  1  registered; high in HIGH_ALERT or EMERGENCY.
- emergency_landing_alert  output  1  registered; high only in EMERGENCY.
- ECSU_state  output  2  current state: 00 ALL_CLEAR, 01 CAUTION, 10 HIGH_ALERT, 11 EMERGENCY.

Behaviour:
- Reset: on a rising CLK edge with RST=1, state=ALL_CLEAR and both flags=0. RST has priority over every transition, including exit from EMERGENCY.
- All comparisons are strict. Temperature comparisons are signed.
  - temp_high = temperature > 35 or temperature < -35.
  - temp_emerg = temperature > 40 or temperature < -40.
- ALL_CLEAR:
  - Go to CAUTION if wind > 10 or visibility == 01.
  - Otherwise stay. Visibility 10/11 alone does not leave ALL_CLEAR.
- CAUTION, checked in this priority order:
  - Go to HIGH_ALERT if thunderstorm, or wind > 15, or temp_high, or visibility == 11.
  - Else go to ALL_CLEAR if wind <= 10 and visibility == 00.
  - Else stay.
- HIGH_ALERT, checked in this priority order:
  - Go to EMERGENCY if temp_emerg or wind > 20.
  - Else go to CAUTION if !thunderstorm and wind <= 10 and temperature in [-35, 35] and visibility == 01.
  - Else stay.
- EMERGENCY: absorbing; left only by reset.
- Transition rules:
  - One transition per edge; no level skipping (e.g. wind=25 from ALL_CLEAR takes 3 edges to reach EMERGENCY).
  - Inputs are sampled at the edge. Mid-cycle input changes have no effect until the next edge.
- Outputs:
  - Flags are derived from the next state and registered together with it, so they change on the same edge as ECSU_state.
- Boundary values: wind=15 and temperature=40 are not emergency; wind=16 is high alert; temperature=-40 is not emergency but is high alert.

Decomposition:
- Package ecsu_pkg:
  - 2-bit state enum (ALL_CLEAR=2'b00, CAUTION=2'b01, HIGH_ALERT=2'b10, EMERGENCY=2'b11).
  - Visibility codes (VIS_CLEAR, VIS_MODERATE, VIS_LOW, VIS_POOR).
  - Default threshold constants.
- Optional sub-module ecsu_cond_decode: purely combinational; produces caution_cond, clear_cond, high_cond, deescalate_cond and emerg_cond from the raw inputs. The top level holds the state register and output registers.

Test Plan:
- RST=1 for 1 edge, then all inputs 0 -> state 00, severe_weather=0, emergency_landing_alert=0.
- From ALL_CLEAR: wind=12 -> CAUTION. Then wind=5, vis=00 -> ALL_CLEAR. Then vis=01 -> CAUTION.
- From CAUTION: thunderstorm=1, wind=5, vis=01, temp=25 -> HIGH_ALERT, severe_weather=1. Then thunderstorm=0 -> CAUTION, severe=0. Then wind=3, vis=00, temp=-5 -> ALL_CLEAR. Then vis=11 -> stays ALL_CLEAR.
- Escalation: wind=25, vis=10 held 5 edges -> 01, 10, 11 on successive edges, then stays 11 with both flags=1. Inputs zeroed -> stays 11. RST=1 -> 00, flags 0.
- Boundaries: in CAUTION with wind=15, vis=01 -> stays CAUTION. temp=40 -> HIGH_ALERT, and it stays HIGH_ALERT (no emergency at 40 or wind 15). Then wind=5, vis=01, temp=25 -> CAUTION.
- Then wind=25, vis=01, temp=-40 -> HIGH_ALERT, then EMERGENCY on the next edge via wind > 20.
